// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM with retire counter
module mips_mc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        regWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        pcWrite,
    output logic [4:0]  ALUOperation,
    output logic [1:0]  sm1,
    output logic [1:0]  sm2,
    output logic [1:0]  sm3,
    output logic [1:0]  sm4,
    output logic [1:0]  sm5,
    output logic        done,
    output logic        illegal,
    output logic [31:0] instCount
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] EX_R     = 4'd2;
    localparam logic [3:0] WB_R     = 4'd3;
    localparam logic [3:0] EX_I     = 4'd4;
    localparam logic [3:0] WB_I     = 4'd5;
    localparam logic [3:0] MEM_ADDR = 4'd6;
    localparam logic [3:0] MEM_RD   = 4'd7;
    localparam logic [3:0] WB_LW    = 4'd8;
    localparam logic [3:0] MEM_WR   = 4'd9;
    localparam logic [3:0] BRANCH   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;
    localparam logic [3:0] JAL      = 4'd12;
    localparam logic [3:0] JR       = 4'd13;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;

    logic [3:0]  state, next_state;
    logic [4:0]  alu_q, dec_alu;
    logic        is_lw_q;
    logic [31:0] count_q;
    logic        dec_illegal;

    logic        o_rw, o_mr, o_mw, o_ir, o_pw, o_done, o_ill;
    logic [4:0]  o_alu;
    logic [1:0]  o_sm1, o_sm2, o_sm3, o_sm4, o_sm5;

    // Decode is only meaningful in DECODE; the ALU op is latched there so EX/WB hold it.
    always_comb begin
        next_state  = FETCH;
        dec_alu     = ALU_ADD;
        dec_illegal = 1'b0;
        case (state)
            FETCH:    next_state = DECODE;
            DECODE: begin
                case (opcode)
                    6'h00: begin
                        case (funct)
                            6'h20: begin next_state = EX_R; dec_alu = ALU_ADD; end
                            6'h22: begin next_state = EX_R; dec_alu = ALU_SUB; end
                            6'h24: begin next_state = EX_R; dec_alu = ALU_AND; end
                            6'h25: begin next_state = EX_R; dec_alu = ALU_OR;  end
                            6'h2A: begin next_state = EX_R; dec_alu = ALU_SLT; end
                            6'h08: next_state = JR;
                            default: dec_illegal = 1'b1;
                        endcase
                    end
                    6'h08: begin next_state = EX_I; dec_alu = ALU_ADD; end
                    6'h0A: begin next_state = EX_I; dec_alu = ALU_SLT; end
                    6'h23, 6'h2B: next_state = MEM_ADDR;
                    6'h04: next_state = BRANCH;
                    6'h02: next_state = JUMP;
                    6'h03: next_state = JAL;
                    default: dec_illegal = 1'b1;
                endcase
            end
            EX_R:     next_state = WB_R;
            EX_I:     next_state = WB_I;
            MEM_ADDR: next_state = is_lw_q ? MEM_RD : MEM_WR;
            MEM_RD:   next_state = WB_LW;
            default:  next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            alu_q   <= ALU_ADD;
            is_lw_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state <= next_state;
            if (state == DECODE) begin
                alu_q   <= dec_alu;
                is_lw_q <= (opcode == 6'h23);
            end
            if (o_done)
                count_q <= count_q + 32'd1;
        end
    end

    always_comb begin
        o_rw = 1'b0; o_mr = 1'b0; o_mw = 1'b0; o_ir = 1'b0; o_pw = 1'b0;
        o_done = 1'b0; o_ill = 1'b0; o_alu = ALU_ADD;
        o_sm1 = 2'd0; o_sm2 = 2'd0; o_sm3 = 2'd0; o_sm4 = 2'd0; o_sm5 = 2'd0;
        case (state)
            FETCH:    begin o_ir = 1'b1; o_pw = 1'b1; end
            DECODE:   o_ill = dec_illegal;
            EX_R:     o_alu = alu_q;
            WB_R:     begin o_alu = alu_q; o_sm1 = 2'd1; o_sm4 = 2'd1; o_sm2 = 2'd1; o_rw = 1'b1; o_done = 1'b1; end
            EX_I:     begin o_alu = alu_q; o_sm3 = 2'd1; end
            WB_I:     begin o_alu = alu_q; o_sm3 = 2'd1; o_sm4 = 2'd1; o_sm2 = 2'd1; o_rw = 1'b1; o_done = 1'b1; end
            MEM_ADDR: o_sm3 = 2'd1;
            MEM_RD:   begin o_sm3 = 2'd1; o_mr = 1'b1; end
            WB_LW:    begin o_sm3 = 2'd1; o_mr = 1'b1; o_sm2 = 2'd1; o_rw = 1'b1; o_done = 1'b1; end
            MEM_WR:   begin o_sm3 = 2'd1; o_mw = 1'b1; o_done = 1'b1; end
            BRANCH:   begin o_alu = ALU_SUB; o_sm5 = 2'd1; o_pw = zero; o_done = 1'b1; end
            JUMP:     begin o_sm5 = 2'd2; o_pw = 1'b1; o_done = 1'b1; end
            JAL:      begin o_sm5 = 2'd2; o_pw = 1'b1; o_done = 1'b1; o_sm1 = 2'd2; o_rw = 1'b1; end
            JR:       begin o_sm5 = 2'd3; o_pw = 1'b1; o_done = 1'b1; end
            default:  ;
        endcase
    end

    // Outputs are forced quiet while reset is held, whatever state the FSM was in.
    assign regWrite     = o_rw   & ~rst;
    assign memRead      = o_mr   & ~rst;
    assign memWrite     = o_mw   & ~rst;
    assign irWrite      = o_ir   & ~rst;
    assign pcWrite      = o_pw   & ~rst;
    assign done         = o_done & ~rst;
    assign illegal      = o_ill  & ~rst;
    assign ALUOperation = rst ? 5'd0 : o_alu;
    assign sm1          = rst ? 2'd0 : o_sm1;
    assign sm2          = rst ? 2'd0 : o_sm2;
    assign sm3          = rst ? 2'd0 : o_sm3;
    assign sm4          = rst ? 2'd0 : o_sm4;
    assign sm5          = rst ? 2'd0 : o_sm5;
    assign instCount    = rst ? 32'd0 : count_q;
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - directed self-checking bench for mips_mc_controller
module tb_mips_mc_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode, funct;
    logic        zero;
    logic        regWrite, memRead, memWrite, irWrite, pcWrite, done, illegal;
    logic [4:0]  ALUOperation;
    logic [1:0]  sm1, sm2, sm3, sm4, sm5;
    logic [31:0] instCount;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    mips_mc_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
        .irWrite(irWrite), .pcWrite(pcWrite), .ALUOperation(ALUOperation),
        .sm1(sm1), .sm2(sm2), .sm3(sm3), .sm4(sm4), .sm5(sm5),
        .done(done), .illegal(illegal), .instCount(instCount)
    );

    always #5 clk = ~clk;

    // {rw,mr,mw,ir,pw,done,illegal,sm1,sm2,sm3,sm4,sm5,alu}
    function automatic logic [21:0] ev(input logic rw, mr, mw, ir, pw, dn, il,
                                       input logic [1:0] s1, s2, s3, s4, s5,
                                       input logic [4:0] alu);
        return {rw, mr, mw, ir, pw, dn, il, s1, s2, s3, s4, s5, alu};
    endfunction

    function automatic logic [21:0] obs();
        return {regWrite, memRead, memWrite, irWrite, pcWrite, done, illegal,
                sm1, sm2, sm3, sm4, sm5, ALUOperation};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Check outputs of the current cycle, then move to the next cycle.
    task automatic cyc(input string tag, input logic [21:0] e);
        #1;
        chk(tag, {10'd0, obs()}, {10'd0, e});
        chk({tag, "_excl"}, {31'd0, (regWrite & memWrite) | (memWrite & pcWrite)}, 32'd0);
        @(negedge clk);
    endtask

    task automatic cnt(input string tag);
        #1;
        chk(tag, instCount, exp_cnt);
    endtask

    logic [21:0] e_fetch, e_zero;

    initial begin
        e_fetch = ev(0,0,0,1,1,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 5'd0);
        e_zero  = 22'd0;
        rst = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cnt("reset_count");
        cyc("reset_outputs", e_zero);
        rst = 1'b0;

        // add
        opcode = 6'h00; funct = 6'h20;
        cyc("add_fetch", e_fetch);
        cyc("add_decode", e_zero);
        cyc("add_ex", e_zero);
        cyc("add_wb", ev(1,0,0,0,0,1,0, 2'd1,2'd1,2'd0,2'd1,2'd0, 5'd0));
        exp_cnt = 1; cnt("add_count");

        // sub
        funct = 6'h22;
        cyc("sub_fetch", e_fetch);
        cyc("sub_decode", e_zero);
        cyc("sub_ex", ev(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 5'd1));
        cyc("sub_wb", ev(1,0,0,0,0,1,0, 2'd1,2'd1,2'd0,2'd1,2'd0, 5'd1));
        exp_cnt = 2; cnt("sub_count");

        // or
        funct = 6'h25;
        cyc("or_fetch", e_fetch);
        cyc("or_decode", e_zero);
        cyc("or_ex", ev(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 5'd3));
        cyc("or_wb", ev(1,0,0,0,0,1,0, 2'd1,2'd1,2'd0,2'd1,2'd0, 5'd3));
        exp_cnt = 3; cnt("or_count");

        // slti
        opcode = 6'h0A; funct = 6'h00;
        cyc("slti_fetch", e_fetch);
        cyc("slti_decode", e_zero);
        cyc("slti_ex", ev(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0,2'd0, 5'd4));
        cyc("slti_wb", ev(1,0,0,0,0,1,0, 2'd0,2'd1,2'd1,2'd1,2'd0, 5'd4));
        exp_cnt = 4; cnt("slti_count");

        // lw
        opcode = 6'h23;
        cyc("lw_fetch", e_fetch);
        cyc("lw_decode", e_zero);
        cyc("lw_addr", ev(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0,2'd0, 5'd0));
        cyc("lw_rd", ev(0,1,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0,2'd0, 5'd0));
        cyc("lw_wb", ev(1,1,0,0,0,1,0, 2'd0,2'd1,2'd1,2'd0,2'd0, 5'd0));
        exp_cnt = 5; cnt("lw_count");

        // sw
        opcode = 6'h2B;
        cyc("sw_fetch", e_fetch);
        cyc("sw_decode", e_zero);
        cyc("sw_addr", ev(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0,2'd0, 5'd0));
        cyc("sw_wr", ev(0,0,1,0,0,1,0, 2'd0,2'd0,2'd1,2'd0,2'd0, 5'd0));
        exp_cnt = 6; cnt("sw_count");

        // beq taken then not taken
        opcode = 6'h04; zero = 1'b1;
        cyc("beq1_fetch", e_fetch);
        cyc("beq1_decode", e_zero);
        cyc("beq1_branch", ev(0,0,0,0,1,1,0, 2'd0,2'd0,2'd0,2'd0,2'd1, 5'd1));
        zero = 1'b0;
        cyc("beq0_fetch", e_fetch);
        cyc("beq0_decode", e_zero);
        cyc("beq0_branch", ev(0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0,2'd1, 5'd1));
        exp_cnt = 8; cnt("beq_count");

        // j, jal, jr
        opcode = 6'h02;
        cyc("j_fetch", e_fetch);
        cyc("j_decode", e_zero);
        cyc("j_jump", ev(0,0,0,0,1,1,0, 2'd0,2'd0,2'd0,2'd0,2'd2, 5'd0));
        opcode = 6'h03;
        cyc("jal_fetch", e_fetch);
        cyc("jal_decode", e_zero);
        cyc("jal_jump", ev(1,0,0,0,1,1,0, 2'd2,2'd0,2'd0,2'd0,2'd2, 5'd0));
        opcode = 6'h00; funct = 6'h08;
        cyc("jr_fetch", e_fetch);
        cyc("jr_decode", e_zero);
        cyc("jr_jump", ev(0,0,0,0,1,1,0, 2'd0,2'd0,2'd0,2'd0,2'd3, 5'd0));
        exp_cnt = 11; cnt("jump_count");

        // illegal opcode and illegal funct
        opcode = 6'h3F;
        cyc("ill_fetch", e_fetch);
        cyc("ill_decode", ev(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0,2'd0, 5'd0));
        opcode = 6'h00; funct = 6'h01;
        cyc("illf_fetch", e_fetch);
        cyc("illf_decode", ev(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0,2'd0, 5'd0));
        cnt("ill_count");

        // reset during MEM_WR
        opcode = 6'h2B;
        cyc("rsw_fetch", e_fetch);
        cyc("rsw_decode", e_zero);
        cyc("rsw_addr", ev(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0,2'd0, 5'd0));
        rst = 1'b1;
        cyc("rsw_wr_in_reset", e_zero);
        exp_cnt = 0; cnt("rsw_count");
        rst = 1'b0;
        cyc("rsw_after_fetch", e_fetch);
        cyc("rsw_after_decode", e_zero);
        cnt("rsw_count_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
